// File: rtl/dwc_capture.sv
// dwc_capture: gathers one result word from each of two redundant cores,
// presents the pair to the DWC comparator, waits for its verdict, records
// pass/fail and re-arms the comparator. Watchdogs both the arrival window
// and the comparator response.
module dwc_capture #(
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned CNT_W          = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              core_a_valid,
   input  logic [DATA_W-1:0] core_a_data,
   output logic              core_a_ready,
   input  logic              core_b_valid,
   input  logic [DATA_W-1:0] core_b_data,
   output logic              core_b_ready,
   output logic [DATA_W-1:0] data_a,
   output logic [DATA_W-1:0] data_b,
   output logic [31:0]       data_set,
   output logic              cmp_rst,
   input  logic              cmp_done,
   input  logic [31:0]       cmp_match,
   output logic              round_done,
   output logic              round_match,
   output logic              timeout_fault,
   output logic              mismatch_fault,
   output logic [CNT_W-1:0]  mismatch_count,
   output logic [CNT_W-1:0]  timeout_count,
   input  logic              clear_fault
);

   localparam int unsigned     TMR_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0]     SET_PAIR = 32'd3;
   localparam logic [31:0]     SET_IDLE = 32'd0;

   typedef enum logic [2:0] {
      COLLECT,
      PRESENT,
      WAIT_CMP,
      RESULT,
      REARM0,
      REARM1
   } state_t;

   state_t            state_q, state_d;
   logic              have_a_q, have_a_d;
   logic              have_b_q, have_b_d;
   logic [DATA_W-1:0] data_a_d, data_b_d;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic              xfer_a, xfer_b;
   logic              tmo_hit, mis_hit;
   logic              core_a_ready_d, core_b_ready_d;
   logic [31:0]       data_set_d;
   logic              cmp_rst_d;
   logic              round_done_d, round_match_d;
   logic              timeout_fault_d, mismatch_fault_d;
   logic [CNT_W-1:0]  mismatch_count_d, timeout_count_d;

   // Only bit0 of the comparator result carries the verdict.
   logic unused_cmp_hi;
   assign unused_cmp_hi = ^cmp_match[31:1];

   assign xfer_a = core_a_valid & core_a_ready;
   assign xfer_b = core_b_valid & core_b_ready;

   // Next-state, datapath and next-output decode.
   always_comb begin
      state_d          = state_q;
      have_a_d         = have_a_q;
      have_b_d         = have_b_q;
      data_a_d         = data_a;
      data_b_d         = data_b;
      timer_d          = timer_q;
      tmo_hit          = 1'b0;
      mis_hit          = 1'b0;
      round_done_d     = 1'b0;
      round_match_d    = 1'b0;
      timeout_fault_d  = timeout_fault;
      mismatch_fault_d = mismatch_fault;
      timeout_count_d  = timeout_count;
      mismatch_count_d = mismatch_count;

      case (state_q)
         COLLECT: begin
            if (xfer_a) begin
               have_a_d = 1'b1;
               data_a_d = core_a_data;
            end
            if (xfer_b) begin
               have_b_d = 1'b1;
               data_b_d = core_b_data;
            end
            if (have_a_d && have_b_d) begin
               state_d = PRESENT;
            end else if (have_a_q ^ have_b_q) begin
               if (timer_q == TMR_LAST) begin
                  tmo_hit = 1'b1;
               end else begin
                  timer_d = timer_q + TMR_W'(1);
               end
            end else if (xfer_a || xfer_b) begin
               timer_d = '0;
            end
         end
         PRESENT: begin
            state_d = WAIT_CMP;
            timer_d = '0;
         end
         WAIT_CMP: begin
            if (cmp_done) begin
               state_d       = RESULT;
               round_done_d  = 1'b1;
               round_match_d = cmp_match[0];
            end else if (timer_q == TMR_LAST) begin
               tmo_hit = 1'b1;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         RESULT: begin
            mis_hit = ~round_match;
            state_d = REARM0;
         end
         REARM0: begin
            state_d = REARM1;
         end
         REARM1: begin
            state_d  = COLLECT;
            have_a_d = 1'b0;
            have_b_d = 1'b0;
            timer_d  = '0;
         end
         default: begin
            state_d = COLLECT;
         end
      endcase

      // A watchdog expiry aborts the round as a failed one.
      if (tmo_hit) begin
         state_d       = REARM0;
         round_done_d  = 1'b1;
         round_match_d = 1'b0;
      end

      // Sticky flags and saturating counters; clear wins over a same-cycle event.
      if (clear_fault) begin
         timeout_fault_d  = 1'b0;
         mismatch_fault_d = 1'b0;
         timeout_count_d  = '0;
         mismatch_count_d = '0;
      end else begin
         if (tmo_hit) begin
            timeout_fault_d = 1'b1;
            if (timeout_count != '1) begin
               timeout_count_d = timeout_count + CNT_W'(1);
            end
         end
         if (mis_hit) begin
            mismatch_fault_d = 1'b1;
            if (mismatch_count != '1) begin
               mismatch_count_d = mismatch_count + CNT_W'(1);
            end
         end
      end

      core_a_ready_d = (state_d == COLLECT) && !have_a_d;
      core_b_ready_d = (state_d == COLLECT) && !have_b_d;
      data_set_d     = ((state_d == PRESENT) || (state_d == WAIT_CMP)) ? SET_PAIR : SET_IDLE;
      cmp_rst_d      = (state_d == REARM0) || (state_d == REARM1);
   end

   // State, datapath and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= COLLECT;
         have_a_q       <= 1'b0;
         have_b_q       <= 1'b0;
         data_a         <= '0;
         data_b         <= '0;
         timer_q        <= '0;
         core_a_ready   <= 1'b1;
         core_b_ready   <= 1'b1;
         data_set       <= SET_IDLE;
         cmp_rst        <= 1'b0;
         round_done     <= 1'b0;
         round_match    <= 1'b0;
         timeout_fault  <= 1'b0;
         mismatch_fault <= 1'b0;
         timeout_count  <= '0;
         mismatch_count <= '0;
      end else begin
         state_q        <= state_d;
         have_a_q       <= have_a_d;
         have_b_q       <= have_b_d;
         data_a         <= data_a_d;
         data_b         <= data_b_d;
         timer_q        <= timer_d;
         core_a_ready   <= core_a_ready_d;
         core_b_ready   <= core_b_ready_d;
         data_set       <= data_set_d;
         cmp_rst        <= cmp_rst_d;
         round_done     <= round_done_d;
         round_match    <= round_match_d;
         timeout_fault  <= timeout_fault_d;
         mismatch_fault <= mismatch_fault_d;
         timeout_count  <= timeout_count_d;
         mismatch_count <= mismatch_count_d;
      end
   end

endmodule

// File: tb/tb_dwc_capture.sv
// tb_dwc_capture: directed stimulus for dwc_capture with a round-level
// behavioural model checked every cycle, plus hand-computed checkpoints.
module tb_dwc_capture;

   localparam int DATA_W = 32;
   localparam int TMO    = 16;
   localparam int CNT_W  = 2;
   localparam int CMAX   = (1 << CNT_W) - 1;

   localparam int PH_COLLECT = 0;
   localparam int PH_PRESENT = 1;
   localparam int PH_WAIT    = 2;
   localparam int PH_REPORT  = 3;
   localparam int PH_REARM   = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              core_a_valid, core_b_valid;
   logic [DATA_W-1:0] core_a_data, core_b_data;
   logic              core_a_ready, core_b_ready;
   logic [DATA_W-1:0] data_a, data_b;
   logic [31:0]       data_set;
   logic              cmp_rst;
   logic              cmp_done;
   logic [31:0]       cmp_match;
   logic              round_done, round_match;
   logic              timeout_fault, mismatch_fault;
   logic [CNT_W-1:0]  mismatch_count, timeout_count;
   logic              clear_fault;

   int checks = 0;
   int errors = 0;

   dwc_capture #(
      .DATA_W(DATA_W),
      .TIMEOUT_CYCLES(TMO),
      .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .reset(reset),
      .core_a_valid(core_a_valid),
      .core_a_data(core_a_data),
      .core_a_ready(core_a_ready),
      .core_b_valid(core_b_valid),
      .core_b_data(core_b_data),
      .core_b_ready(core_b_ready),
      .data_a(data_a),
      .data_b(data_b),
      .data_set(data_set),
      .cmp_rst(cmp_rst),
      .cmp_done(cmp_done),
      .cmp_match(cmp_match),
      .round_done(round_done),
      .round_match(round_match),
      .timeout_fault(timeout_fault),
      .mismatch_fault(mismatch_fault),
      .mismatch_count(mismatch_count),
      .timeout_count(timeout_count),
      .clear_fault(clear_fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- round-level model ----------------
   int              m_phase, m_budget, m_rearm, m_tc, m_mc;
   bit              m_ha, m_hb, m_rd, m_rm, m_tf, m_mf;
   logic [DATA_W-1:0] m_wa, m_wb;

   task automatic model_step();
      bit was_one, any_before, ta, tbx, prev_rm, inc_t, inc_m, tmo;
      if (!reset) begin
         m_phase = PH_COLLECT; m_budget = 0; m_rearm = 0;
         m_ha = 0; m_hb = 0; m_wa = '0; m_wb = '0;
         m_rd = 0; m_rm = 0; m_tf = 0; m_mf = 0; m_tc = 0; m_mc = 0;
         return;
      end
      inc_t = 0; inc_m = 0; tmo = 0;
      prev_rm = m_rm; m_rd = 0; m_rm = 0;
      case (m_phase)
         PH_COLLECT: begin
            was_one    = m_ha ^ m_hb;
            any_before = m_ha | m_hb;
            ta  = core_a_valid && !m_ha;
            tbx = core_b_valid && !m_hb;
            if (ta)  begin m_ha = 1; m_wa = core_a_data; end
            if (tbx) begin m_hb = 1; m_wb = core_b_data; end
            if (m_ha && m_hb) m_phase = PH_PRESENT;
            else if (!any_before && (ta || tbx)) m_budget = TMO;
            else if (was_one) begin
               m_budget--;
               if (m_budget == 0) tmo = 1;
            end
         end
         PH_PRESENT: begin
            m_phase = PH_WAIT; m_budget = TMO;
         end
         PH_WAIT: begin
            if (cmp_done) begin
               m_phase = PH_REPORT; m_rd = 1; m_rm = cmp_match[0];
            end else begin
               m_budget--;
               if (m_budget == 0) tmo = 1;
            end
         end
         PH_REPORT: begin
            inc_m = !prev_rm; m_phase = PH_REARM; m_rearm = 2;
         end
         default: begin
            m_rearm--;
            if (m_rearm == 0) begin
               m_phase = PH_COLLECT; m_ha = 0; m_hb = 0;
            end
         end
      endcase
      if (tmo) begin
         m_rd = 1; m_rm = 0; inc_t = 1; m_phase = PH_REARM; m_rearm = 2;
      end
      if (clear_fault) begin
         m_tf = 0; m_mf = 0; m_tc = 0; m_mc = 0;
      end else begin
         if (inc_t) begin m_tf = 1; if (m_tc < CMAX) m_tc++; end
         if (inc_m) begin m_mf = 1; if (m_mc < CMAX) m_mc++; end
      end
   endtask

   // Advance the model on the same events as the design.
   always @(posedge clk or negedge reset) model_step();

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      chk("ready_a", 64'(core_a_ready), 64'((m_phase == PH_COLLECT) && !m_ha));
      chk("ready_b", 64'(core_b_ready), 64'((m_phase == PH_COLLECT) && !m_hb));
      chk("data_set", 64'(data_set),
          64'(((m_phase == PH_PRESENT) || (m_phase == PH_WAIT)) ? 3 : 0));
      chk("cmp_rst", 64'(cmp_rst), 64'(m_phase == PH_REARM));
      chk("round_done", 64'(round_done), 64'(m_rd));
      chk("round_match", 64'(round_match), 64'(m_rm));
      chk("timeout_fault", 64'(timeout_fault), 64'(m_tf));
      chk("mismatch_fault", 64'(mismatch_fault), 64'(m_mf));
      chk("timeout_count", 64'(timeout_count), 64'(m_tc));
      chk("mismatch_count", 64'(mismatch_count), 64'(m_mc));
      if ((m_phase == PH_PRESENT) || (m_phase == PH_WAIT)) begin
         chk("data_a", 64'(data_a), 64'(m_wa));
         chk("data_b", 64'(data_b), 64'(m_wb));
      end
   end

   // Pulse tallies used by the hand-computed checkpoints.
   int rd_total = 0;
   int rs_total = 0;
   bit last_rm  = 0;
   always @(negedge clk) begin
      if (round_done) begin
         rd_total++;
         last_rm = round_match;
      end
      if (cmp_rst) rs_total++;
   end

   // ---------------- stimulus helpers ----------------
   task automatic nxt();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_ready(input string name);
      int n = 0;
      while (!(core_a_ready && core_b_ready) && n < 60) begin
         nxt();
         n++;
      end
      chk(name, 64'(n < 60), 64'(1));
   endtask

   // Deliver both words; returns with WAIT_CMP visible.
   task automatic deliver(input logic [31:0] a, input logic [31:0] b,
                          input int b_delay, input bit redrive);
      core_a_valid = 1; core_a_data = a;
      if (b_delay == 0) begin core_b_valid = 1; core_b_data = b; end
      nxt();
      core_a_valid = 0; core_b_valid = 0;
      if (b_delay > 0) begin
         repeat (b_delay - 1) nxt();
         core_b_valid = 1; core_b_data = b;
         nxt();
         core_b_valid = 0;
      end
      chk("present_data_set", 64'(data_set), 64'(3));
      chk("present_data_a", 64'(data_a), 64'(a));
      if (redrive) begin
         core_a_valid = 1; core_a_data = 32'h0BAD_0BAD;
      end
      nxt();
      core_a_valid = 0;
   endtask

   // Comparator response; optionally clears faults during the result cycle.
   task automatic respond(input int delay, input bit match, input bit clr);
      repeat (delay) nxt();
      cmp_done = 1; cmp_match = {31'h2AAA_AAAA, match};
      nxt();
      cmp_done = 0; cmp_match = '0;
      if (clr) begin
         clear_fault = 1;
         nxt();
         clear_fault = 0;
      end
   endtask

   task automatic full_round(input logic [31:0] a, input logic [31:0] b, input bit clr);
      int rd0, rs0;
      rd0 = rd_total; rs0 = rs_total;
      deliver(a, b, 0, 0);
      respond(2, a == b, clr);
      wait_ready("round_ready_back");
      chk("round_pulses", 64'(rd_total - rd0), 64'(1));
      chk("rearm_cycles", 64'(rs_total - rs0), 64'(2));
      chk("round_verdict", 64'(last_rm), 64'(a == b));
   endtask

   // Global time limit.
   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1);
   end

   initial begin
      int k, rd0, rs0;
      reset = 0;
      core_a_valid = 0; core_b_valid = 0; core_a_data = '0; core_b_data = '0;
      cmp_done = 0; cmp_match = '0; clear_fault = 0;
      nxt(); nxt();
      chk("rst_ready_a", 64'(core_a_ready), 64'(1));
      chk("rst_data_set", 64'(data_set), 64'(0));
      chk("rst_counts", 64'({mismatch_count, timeout_count}), 64'(0));
      reset = 1;
      nxt();

      // Stray comparator done while idle is ignored.
      cmp_done = 1; cmp_match = '0;
      nxt();
      cmp_done = 0;

      // Round 1: simultaneous equal words.
      rd0 = rd_total; rs0 = rs_total;
      deliver(32'h1234_5678, 32'h1234_5678, 0, 0);
      respond(3, 1, 0);
      wait_ready("t1_ready_back");
      chk("t1_pulses", 64'(rd_total - rd0), 64'(1));
      chk("t1_match", 64'(last_rm), 64'(1));
      chk("t1_rearm_cycles", 64'(rs_total - rs0), 64'(2));
      chk("t1_counts", 64'({mismatch_count, timeout_count}), 64'(0));

      // Round 2: B five cycles late, mismatch, A re-driven during PRESENT.
      deliver(32'hDEAD_BEEF, 32'hDEAD_BEEE, 5, 1);
      chk("t2_data_a_held", 64'(data_a), 64'(32'hDEAD_BEEF));
      respond(1, 0, 0);
      wait_ready("t2_ready_back");
      chk("t2_match", 64'(last_rm), 64'(0));
      chk("t2_mismatch_fault", 64'(mismatch_fault), 64'(1));
      chk("t2_mismatch_count", 64'(mismatch_count), 64'(1));

      // Round 3: only A arrives; arrival watchdog fires.
      core_a_valid = 1; core_a_data = 32'hA5A5_0001;
      k = 0;
      do begin
         nxt();
         core_a_valid = 0;
         k++;
      end while (!round_done && k < 40);
      chk("t3_timeout_edges", 64'(k - 1), 64'(TMO));
      chk("t3_match", 64'(round_match), 64'(0));
      wait_ready("t3_ready_back");
      chk("t3_timeout_fault", 64'(timeout_fault), 64'(1));
      chk("t3_timeout_count", 64'(timeout_count), 64'(1));
      full_round(32'hCAFE_F00D, 32'hCAFE_F00D, 0);

      // Round 4: comparator never answers.
      rs0 = rs_total;
      deliver(32'h0000_0042, 32'h0000_0042, 0, 0);
      wait_ready("t4_ready_back");
      chk("t4_timeout_count", 64'(timeout_count), 64'(2));
      chk("t4_rearm_cycles", 64'(rs_total - rs0), 64'(2));
      chk("t4_match", 64'(last_rm), 64'(0));

      // Clear, then saturate mismatch count with five bad rounds.
      clear_fault = 1;
      nxt();
      clear_fault = 0;
      chk("clr_counts", 64'({mismatch_count, timeout_count}), 64'(0));
      chk("clr_flags", 64'({mismatch_fault, timeout_fault}), 64'(0));
      for (int i = 0; i < 5; i++) full_round(32'h1000_0000 + i, 32'h2000_0000 + i, 0);
      chk("sat_mismatch_count", 64'(mismatch_count), 64'(CMAX));
      full_round(32'h3333_3333, 32'h3333_3334, 1);
      chk("clr_vs_inc_count", 64'(mismatch_count), 64'(0));
      chk("clr_vs_inc_flag", 64'(mismatch_fault), 64'(0));

      // Async reset in WAIT_CMP.
      full_round(32'h4444_4444, 32'h4444_0000, 0);
      deliver(32'h5555_5555, 32'h5555_5555, 0, 0);
      nxt();
      #1 reset = 0;
      #1;
      chk("arst_ready", 64'({core_a_ready, core_b_ready}), 64'(3));
      chk("arst_data_set", 64'(data_set), 64'(0));
      chk("arst_data", 64'({data_a, data_b}), 64'(0));
      chk("arst_pulses", 64'({cmp_rst, round_done, round_match}), 64'(0));
      chk("arst_faults", 64'({mismatch_fault, timeout_fault, mismatch_count, timeout_count}), 64'(0));
      nxt();
      reset = 1;
      nxt();
      full_round(32'h6666_7777, 32'h6666_7777, 0);
      chk("post_rst_match", 64'(last_rm), 64'(1));

      repeat (3) nxt();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dwc_capture.md
Name: dwc_capture

Overview:
- Upstream feeder for the dual-core DWC comparator.
- Collects one result word from each of two redundant cores (independent valid/ready handshakes) and presents the pair on data_a/data_b with data_set=3.
- Waits for the comparator's done pulse, then records pass/fail and re-arms the comparator for the next round.
- Watchdogs both the core-arrival window and the comparator response, with saturating mismatch and timeout counters.

Parameters:
- DATA_W, 32, width of core result words and comparator data ports
- TIMEOUT_CYCLES, 1024, max cycles from first core arrival to second arrival; also max cycles in WAIT_CMP
- CNT_W, 16, width of mismatch_count and timeout_count (saturating)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- core_a_valid  in  1  core A result valid
- core_a_data  in  DATA_W  core A result
- core_a_ready  out  1  core A slot empty; transfer on valid&&ready
- core_b_valid  in  1  core B result valid
- core_b_data  in  DATA_W  core B result
- core_b_ready  out  1  core B slot empty
- data_a  out  DATA_W  latched core A word to comparator
- data_b  out  DATA_W  latched core B word to comparator
- data_set  out  32  3 while the pair is presented, else 0
- cmp_rst  out  1  active-high re-arm pulse to comparator
- cmp_done  in  1  comparator done pulse (interupt_match)
- cmp_match  in  32  comparator result; bit0=1 means match
- round_done  out  1  1-cycle pulse per completed or aborted round
- round_match  out  1  valid with round_done; 1 = cores agreed
- timeout_fault  out  1  sticky: arrival or comparator timeout
- mismatch_fault  out  1  sticky: any mismatched round
- mismatch_count  out  CNT_W  saturating count of mismatched rounds
- timeout_count  out  CNT_W  saturating count of timeouts
- clear_fault  in  1  synchronous clear of sticky flags and both counters

Behaviour:
- Reset (reset=0, async):
  - state COLLECT; slot flags, data_a/data_b, timer and counters = 0.
  - Both ready = 1; data_set = 0; cmp_rst = 0; round_done = 0; round_match = 0; both faults = 0.
- FSM states: COLLECT, PRESENT, WAIT_CMP, RESULT, REARM0, REARM1.
- COLLECT:
  - core_x_ready = ~have_x; a transfer latches data into data_x and sets have_x.
  - A and B may transfer in the same cycle.
  - valid while have_x=1 is ignored; the source holds its data.
  - Timer clears to 0 on the first transfer and increments each cycle while exactly one flag is set.
  - have_a&&have_b -> PRESENT.
  - Timer reaches TIMEOUT_CYCLES-1 with one flag set -> timeout_fault=1, timeout_count+1, round_done pulse with round_match=0, discard latched word, go to REARM0.
- PRESENT: data_set=3, both ready=0, data_a/data_b stable; next cycle -> WAIT_CMP with timer cleared.
- WAIT_CMP:
  - data_set=3 and data held constant.
  - cmp_done=1 -> capture cmp_match[0], go to RESULT.
  - Timer reaches TIMEOUT_CYCLES-1 first -> timeout handling as in COLLECT, go to REARM0.
- RESULT:
  - round_done=1 for exactly this cycle; round_match=captured bit.
  - On mismatch: mismatch_fault=1 and mismatch_count+1.
  - -> REARM0.
- REARM0/REARM1:
  - data_set=0, cmp_rst=1 for exactly 2 cycles. Two cycles are needed because the comparator registers its next-state and needs data_set≠3 while in reset.
  - Then clear have_a/have_b and go to COLLECT; ready reasserts the cycle after REARM1.
- data_set, cmp_rst and ready decode from registered state only (glitch-free).
- Counters saturate at 2^CNT_W-1.
- clear_fault:
  - Clears flags and counters at the next edge and has priority over a same-cycle increment.
  - Does not affect the FSM.
- A cmp_done outside WAIT_CMP is ignored.

Test Plan:
- Both cores valid in the same cycle, A=B=0x1234_5678, comparator model -> data_set=3 one cycle later; one round_done pulse with round_match=1; counters 0; cmp_rst high exactly 2 cycles; ready high again afterwards.
- A=0xDEAD_BEEF, B=0xDEAD_BEEE, B arriving 5 cycles after A -> round_match=0, mismatch_fault=1, mismatch_count=1; A valid re-driven during PRESENT is not accepted.
- TIMEOUT_CYCLES=16, only A sends -> round_done with round_match=0 at the 16th cycle after A's transfer; timeout_fault=1, timeout_count=1; next round completes normally.
- Comparator model never asserts cmp_done -> timeout after 16 cycles in WAIT_CMP; cmp_rst pulse; return to COLLECT.
- CNT_W=2, 5 mismatched rounds -> mismatch_count stops at 3; clear_fault coinciding with a mismatch in RESULT -> count 0, flag 0.
- reset driven low during WAIT_CMP, asynchronously -> all outputs at reset values immediately; after release, a fresh round completes with round_match=1.
